// File: rtl/dcache_mem_pkg.sv
// ---------------------------------------------------------------------------
// dcache_mem_pkg
// Shared types and helpers for the data-cache memory responder.
//   resp_state_t : responder FSM states
//   SZ_*         : mem_size encodings (bit 1 set means word)
//   line_words() : words per cache line for a given byte-offset width
//   byte_en()    : 4-bit lane mask for a single-word access
// ---------------------------------------------------------------------------
package dcache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LAT  = 2'd1,
        XFER = 2'd2
    } resp_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic int line_words(input int offset_w);
        return 1 << (offset_w - 2);
    endfunction

    // Lane mask for a single-word store. Data is already lane-aligned by the
    // initiator, so only the enables depend on the address.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        if (size[1]) begin
            be = 4'b1111;
        end else if (size[0]) begin
            be = addr_lo[1] ? 4'b1100 : 4'b0011;
        end else begin
            be = 4'b0001 << addr_lo;
        end
        return be;
    endfunction

endpackage

// File: rtl/dcache_mem_ram.sv
// ---------------------------------------------------------------------------
// dcache_mem_ram
// Single-port word RAM, 2**ADDR_W x 32, with per-byte write enables and a
// registered read port (data appears the cycle after the address).
// Ports:
//   clk, resetn : clock, async active-low reset (read register only)
//   addr        : word address
//   we          : byte write enables, lane i = wdata[8i+7:8i]
//   wdata       : write data
//   rdata       : registered read data (old contents on a write cycle)
// Array contents are intentionally not reset.
// ---------------------------------------------------------------------------
module dcache_mem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] ram_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                ram_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= ram_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// ---------------------------------------------------------------------------
// dcache_mem_responder
// Memory-side responder for the data-cache refill/writeback interface,
// backed by an internal word RAM. One request per transaction: a burst moves
// a full line (LINE_WORDS beats), a single moves one word with byte/half/word
// size. RESP_LATENCY idle cycles separate acceptance from the first beat.
//
// Build option: DCACHE_MEM_WRAP_BURST_EN
//   defined   : burst reads are critical-word-first, wrapping within the line
//   undefined : every burst starts at word 0 of the line
//
// Ports:
//   clk, resetn  : clock, async active-low reset
//   mem_req      : request valid, held until mem_addr_ok
//   mem_wr       : 1 write, 0 read
//   mem_burst    : 1 full line, 0 single word
//   mem_size     : 00 byte, 01 half, 1x word (single only)
//   mem_addr     : byte address
//   mem_wdata    : write data for the current beat
//   mem_wlast    : initiator's final-write-beat marker
//   mem_addr_ok  : request accepted this cycle (combinational, IDLE only)
//   mem_data_ok  : a data beat completes this cycle
//   mem_rdata    : read data for the current beat
//   resp_err     : sticky protocol error
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; mem_addr_ok follows mem_req, request latched on accept
// LAT   | latency down-count; advance to XFER at terminal count 1
// XFER  | one beat per cycle until the last beat, then back to IDLE
// ---------------------------------------------------------------------------
module dcache_mem_responder
    import dcache_mem_pkg::*;
#(
    parameter int LINE_OFFSET_W = 4,
    parameter int MEM_ADDR_W    = 12,
    parameter int RESP_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic        mem_burst,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_wlast,
    output logic        mem_addr_ok,
    output logic        mem_data_ok,
    output logic [31:0] mem_rdata,
    output logic        resp_err
);

    localparam int WOFF_W     = LINE_OFFSET_W - 2;
    localparam int LINE_WORDS = line_words(LINE_OFFSET_W);
    localparam int AW         = MEM_ADDR_W + 2;
    localparam int LAT_W      = (RESP_LATENCY < 2) ? 1 : $clog2(RESP_LATENCY + 1);

`ifdef DCACHE_MEM_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    resp_state_t       state_q, state_d;
    logic              wr_q, wr_d;
    logic              burst_q, burst_d;
    logic [1:0]        size_q, size_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WOFF_W-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              data_ok_q, data_ok_d;
    logic              err_q, err_d;

    logic                  addr_ok;
    logic                  is_last;
    logic                  misaligned;
    logic [MEM_ADDR_W-1:0] ram_addr;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;

    // Only the RAM-addressable bits are kept; upper bits alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:AW];

    // RAM word for a given beat. Singles use the address as-is. Bursts keep
    // the line part and replace the word offset with the beat number, or with
    // (start word + beat) mod LINE_WORDS for critical-word-first reads.
    function automatic logic [MEM_ADDR_W-1:0] word_index(
        input logic [AW-1:0]     byte_addr,
        input logic              burst,
        input logic              wr,
        input logic [WOFF_W-1:0] beat
    );
        logic [MEM_ADDR_W-1:0] word;
        logic [WOFF_W-1:0]     off;
        word = byte_addr[AW-1:2];
        off  = (WRAP_EN && !wr) ? word[WOFF_W-1:0] + beat : beat;
        if (burst) begin
            word[WOFF_W-1:0] = off;
        end
        return word;
    endfunction

    assign is_last    = burst_q ? (beat_q == WOFF_W'(LINE_WORDS - 1)) : 1'b1;
    assign misaligned = (mem_size[1] && (mem_addr[1:0] != 2'b00)) ||
                        (!mem_size[1] && mem_size[0] && mem_addr[0]);

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        burst_d  = burst_q;
        size_d   = size_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        err_d    = err_q;
        addr_ok  = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = word_index(addr_q, burst_q, wr_q, '0);

        case (state_q)
            IDLE: begin
                // Pre-issue beat 0's read so a zero-latency read has data
                // ready in its first XFER cycle.
                ram_addr = word_index(mem_addr[AW-1:0], mem_burst, mem_wr, '0);
                addr_ok  = mem_req && resetn;
                if (mem_req) begin
                    wr_d    = mem_wr;
                    burst_d = mem_burst;
                    size_d  = mem_size;
                    addr_d  = mem_addr[AW-1:0];
                    beat_d  = '0;
                    lat_d   = LAT_W'(RESP_LATENCY);
                    state_d = (RESP_LATENCY == 0) ? XFER : LAT;
                    if (!mem_burst && misaligned) begin
                        err_d = 1'b1;
                    end
                end
            end

            LAT: begin
                // Last LAT cycle presents beat 0 to the RAM.
                ram_addr = word_index(addr_q, burst_q, wr_q, '0);
                lat_d    = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d = XFER;
                end
            end

            XFER: begin
                if (wr_q) begin
                    ram_addr = word_index(addr_q, burst_q, wr_q, beat_q);
                    ram_we   = burst_q ? 4'b1111 : byte_en(size_q, addr_q[1:0]);
                    if (mem_wlast != is_last) begin
                        err_d = 1'b1;
                    end
                end else begin
                    // Read one beat ahead; the RAM read register is mem_rdata.
                    ram_addr = word_index(addr_q, burst_q, wr_q, beat_q + WOFF_W'(1));
                end
                beat_d = beat_q + WOFF_W'(1);
                if (is_last) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        data_ok_d = (state_d == XFER);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            burst_q   <= 1'b0;
            size_q    <= SZ_BYTE;
            addr_q    <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            burst_q   <= burst_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            data_ok_q <= data_ok_d;
            err_q     <= err_d;
        end
    end

    dcache_mem_ram #(
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .addr   (ram_addr),
        .we     (ram_we),
        .wdata  (mem_wdata),
        .rdata  (ram_rdata)
    );

    assign mem_addr_ok = addr_ok;
    assign mem_data_ok = data_ok_q;
    assign mem_rdata   = ram_rdata;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
module tb_dcache_mem_responder;
    import dcache_mem_pkg::*;

    logic        clk;
    logic        resetn;
    logic        mem_req;
    logic        mem_wr;
    logic        mem_burst;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wlast;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        resp_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rd_got [4];
    int          cyc_got [4];
    int          acc_wait;
    int          beats_got;
    logic        end_dok;

    dcache_mem_responder #(
        .LINE_OFFSET_W (4),
        .MEM_ADDR_W    (12),
        .RESP_LATENCY  (2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_burst   (mem_burst),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wlast   (mem_wlast),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .resp_err    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction. Cycle 0 is the acceptance cycle; cyc_got[] records the
    // cycle of each data beat. abort_beat >= 0 pulls resetn low during that beat.
    task automatic txn(input logic wr, input logic burst, input logic [1:0] size,
                       input logic [31:0] addr,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3,
                       input int wlast_beat, input int abort_beat);
        logic [31:0] wd [4];
        int nb;
        bit accepted;
        bit aborted;
        wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
        nb = burst ? 4 : 1;
        accepted = 0;
        aborted = 0;
        for (int i = 0; i < 4; i++) begin
            rd_got[i] = '0;
            cyc_got[i] = -1;
        end
        @(posedge clk); #1;
        mem_req = 1'b1; mem_wr = wr; mem_burst = burst; mem_size = size;
        mem_addr = addr; mem_wdata = '0; mem_wlast = 1'b0;
        acc_wait = 0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (mem_addr_ok) accepted = 1; else acc_wait++;
            @(posedge clk); #1;
        end
        mem_req = 1'b0;
        beats_got = 0;
        if (accepted) begin
            for (int c = 1; c < 60 && beats_got < nb && !aborted; c++) begin
                if (mem_data_ok) begin
                    rd_got[beats_got] = mem_rdata;
                    cyc_got[beats_got] = c;
                    mem_wdata = wd[beats_got];
                    mem_wlast = (beats_got == wlast_beat);
                    if (beats_got == abort_beat) begin
                        resetn = 1'b0;
                        aborted = 1;
                    end else begin
                        beats_got++;
                    end
                end else begin
                    mem_wdata = '0;
                    mem_wlast = 1'b0;
                end
                if (!aborted) begin
                    @(posedge clk); #1;
                end
            end
        end
        mem_wdata = '0;
        mem_wlast = 1'b0;
        end_dok = mem_data_ok;
        if (!(accepted && (aborted || beats_got == nb))) begin
            n_chk++; n_fail++;
            $display("FAIL txn_timeout: addr %h accepted %0d beats %0d required %0d", addr, accepted, beats_got, nb);
        end
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
        txn(1'b1, 1'b0, SZ_WORD, addr, data, 32'h0, 32'h0, 32'h0, 0, -1);
    endtask

    task automatic test_reset();
        resetn = 1'b0; mem_req = 1'b1; mem_wr = 1'b0; mem_burst = 1'b0;
        mem_size = SZ_BYTE; mem_addr = '0; mem_wdata = '0; mem_wlast = 1'b0;
        #22;
        n_chk++; if (mem_addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok: got %b expected 0", mem_addr_ok); end
        n_chk++; if (mem_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok: got %b expected 0", mem_data_ok); end
        n_chk++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err); end
        mem_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_refill();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'hA000_00A0; exp_v[1] = 32'hA000_00A1;
        exp_v[2] = 32'hA000_00A2; exp_v[3] = 32'hA000_00A3;
        for (int i = 0; i < 4; i++) wr_word(32'h10 + 32'(4 * i), exp_v[i]);
        txn(1'b0, 1'b1, SZ_WORD, 32'h10, 0, 0, 0, 0, 3, -1);
        n_chk++; if (acc_wait !== 0) begin n_fail++; $display("FAIL refill_addr_ok_cycle: got wait %0d expected 0", acc_wait); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (cyc_got[i] !== 3 + i) begin n_fail++; $display("FAIL refill_beat%0d_cycle: got %0d expected %0d", i, cyc_got[i], 3 + i); end
            n_chk++; if (rd_got[i] !== exp_v[i]) begin n_fail++; $display("FAIL refill_beat%0d_data: got %h expected %h", i, rd_got[i], exp_v[i]); end
        end
        n_chk++; if (end_dok !== 1'b0) begin n_fail++; $display("FAIL refill_idle_cycle7: data_ok got %b expected 0", end_dok); end
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL refill_err: got %b expected 0", resp_err); end
    endtask

    task automatic test_writeback();
        logic [31:0] exp_v [4];
        txn(1'b1, 1'b1, SZ_WORD, 32'h20, 32'h11, 32'h22, 32'h33, 32'h44, 3, -1);
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL wb_err_clean: got %b expected 0", resp_err); end
        txn(1'b0, 1'b1, SZ_WORD, 32'h20, 0, 0, 0, 0, 3, -1);
        exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (rd_got[i] !== exp_v[i]) begin n_fail++; $display("FAIL wb1_word%0d: got %h expected %h", i, rd_got[i], exp_v[i]); end
        end
        txn(1'b1, 1'b1, SZ_WORD, 32'h20, 32'h55, 32'h66, 32'h77, 32'h88, 2, -1);
        n_chk++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL wb_err_wlast: got %b expected 1", resp_err); end
        txn(1'b0, 1'b1, SZ_WORD, 32'h20, 0, 0, 0, 0, 3, -1);
        exp_v[0] = 32'h55; exp_v[1] = 32'h66; exp_v[2] = 32'h77; exp_v[3] = 32'h88;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (rd_got[i] !== exp_v[i]) begin n_fail++; $display("FAIL wb2_word%0d: got %h expected %h", i, rd_got[i], exp_v[i]); end
        end
    endtask

    task automatic test_byte_write();
        wr_word(32'h40, 32'h1234_5678);
        txn(1'b1, 1'b0, SZ_BYTE, 32'h43, 32'hAB00_0000, 0, 0, 0, 0, -1);
        txn(1'b0, 1'b0, SZ_WORD, 32'h40, 0, 0, 0, 0, 0, -1);
        n_chk++; if (rd_got[0] !== 32'hAB34_5678) begin n_fail++; $display("FAIL byte_write: got %h expected %h", rd_got[0], 32'hAB34_5678); end
        n_chk++; if (cyc_got[0] !== 3) begin n_fail++; $display("FAIL single_read_cycle: got %0d expected 3", cyc_got[0]); end
        n_chk++; if (end_dok !== 1'b0) begin n_fail++; $display("FAIL single_one_beat: data_ok got %b expected 0", end_dok); end
        txn(1'b1, 1'b0, SZ_HALF, 32'h42, 32'hCDEF_0000, 0, 0, 0, 0, -1);
        txn(1'b0, 1'b0, SZ_BYTE, 32'h41, 0, 0, 0, 0, 0, -1);
        n_chk++; if (rd_got[0] !== 32'hCDEF_5678) begin n_fail++; $display("FAIL half_write_hi: got %h expected %h", rd_got[0], 32'hCDEF_5678); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_v [4];
`ifdef DCACHE_MEM_WRAP_BURST_EN
        exp_v[0] = 32'hA000_00A2; exp_v[1] = 32'hA000_00A3;
        exp_v[2] = 32'hA000_00A0; exp_v[3] = 32'hA000_00A1;
`else
        exp_v[0] = 32'hA000_00A0; exp_v[1] = 32'hA000_00A1;
        exp_v[2] = 32'hA000_00A2; exp_v[3] = 32'hA000_00A3;
`endif
        txn(1'b0, 1'b1, SZ_WORD, 32'h18, 0, 0, 0, 0, 3, -1);
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (rd_got[i] !== exp_v[i]) begin n_fail++; $display("FAIL burst_order_beat%0d: got %h expected %h", i, rd_got[i], exp_v[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [16];
        logic        exp_dok;
        logic        exp_aok;
        for (int i = 0; i < 16; i++) exp_d[i] = '0;
        exp_d[3]  = 32'hA000_00A0; exp_d[4]  = 32'hA000_00A1;
        exp_d[5]  = 32'hA000_00A2; exp_d[6]  = 32'hA000_00A3;
        exp_d[10] = 32'h55; exp_d[11] = 32'h66; exp_d[12] = 32'h77; exp_d[13] = 32'h88;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_wr = 1'b0; mem_burst = 1'b1; mem_size = SZ_WORD; mem_addr = 32'h10;
        @(negedge clk);
        n_chk++; if (mem_addr_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_first_accept: got %b expected 1", mem_addr_ok); end
        for (int c = 1; c < 16; c++) begin
            @(posedge clk); #1;
            if (c == 1) mem_addr = 32'h20;
            if (c == 8) mem_req = 1'b0;
            @(negedge clk);
            exp_dok = (c >= 3 && c <= 6) || (c >= 10 && c <= 13);
            exp_aok = (c == 7);
            n_chk++; if (mem_data_ok !== exp_dok) begin n_fail++; $display("FAIL b2b_data_ok_c%0d: got %b expected %b", c, mem_data_ok, exp_dok); end
            n_chk++; if (mem_addr_ok !== exp_aok) begin n_fail++; $display("FAIL b2b_addr_ok_c%0d: got %b expected %b", c, mem_addr_ok, exp_aok); end
            if (exp_dok) begin
                n_chk++; if (mem_rdata !== exp_d[c]) begin n_fail++; $display("FAIL b2b_rdata_c%0d: got %h expected %h", c, mem_rdata, exp_d[c]); end
            end
        end
    endtask

    task automatic test_abort();
        txn(1'b1, 1'b1, SZ_WORD, 32'h60, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 3, -1);
        n_chk++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL abort_pre_err: got %b expected 1", resp_err); end
        txn(1'b1, 1'b1, SZ_WORD, 32'h60, 32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003, 3, 2);
        #1;
        n_chk++; if (mem_data_ok !== 1'b0) begin n_fail++; $display("FAIL abort_data_ok: got %b expected 0", mem_data_ok); end
        n_chk++; if (mem_addr_ok !== 1'b0) begin n_fail++; $display("FAIL abort_addr_ok: got %b expected 0", mem_addr_ok); end
        n_chk++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL abort_rdata: got %h expected 0", mem_rdata); end
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b expected 0", resp_err); end
        @(negedge clk);
        resetn = 1'b1;
        txn(1'b0, 1'b1, SZ_WORD, 32'h60, 0, 0, 0, 0, 3, -1);
        n_chk++; if (acc_wait !== 0) begin n_fail++; $display("FAIL abort_next_accept: got wait %0d expected 0", acc_wait); end
        n_chk++; if (rd_got[0] !== 32'h6000_0000) begin n_fail++; $display("FAIL abort_beat0: got %h expected %h", rd_got[0], 32'h6000_0000); end
        n_chk++; if (rd_got[1] !== 32'h6000_0001) begin n_fail++; $display("FAIL abort_beat1: got %h expected %h", rd_got[1], 32'h6000_0001); end
        n_chk++; if (rd_got[2] !== 32'hF2) begin n_fail++; $display("FAIL abort_beat2_absent: got %h expected %h", rd_got[2], 32'hF2); end
        n_chk++; if (rd_got[3] !== 32'hF3) begin n_fail++; $display("FAIL abort_beat3_absent: got %h expected %h", rd_got[3], 32'hF3); end
    endtask

    task automatic test_misaligned();
        wr_word(32'h44, 32'h1122_3344);
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL aligned_no_err: got %b expected 0", resp_err); end
        txn(1'b1, 1'b0, SZ_HALF, 32'h45, 32'h0000_BEEF, 0, 0, 0, 0, -1);
        n_chk++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL misaligned_half_err: got %b expected 1", resp_err); end
        txn(1'b0, 1'b0, SZ_WORD, 32'h44, 0, 0, 0, 0, 0, -1);
        n_chk++; if (rd_got[0] !== 32'h1122_BEEF) begin n_fail++; $display("FAIL misaligned_half_data: got %h expected %h", rd_got[0], 32'h1122_BEEF); end
    endtask

    initial begin
        test_reset();
        test_refill();
        test_writeback();
        test_byte_write();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_misaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the data-cache SRAM-like refill/writeback interface.
- Accepts one request per transaction via the req/addr_ok handshake.
- Returns a full line as LINE_WORDS data_ok beats (refill), or consumes a line one word per beat (writeback), against an internal word-addressed RAM.
- Also serves single-word uncached accesses with byte/halfword sizes.
- Used as the memory model in cache-level simulation and as the on-chip scratch backing store.

Parameters:
- LINE_OFFSET_W, 4: byte-offset bits of a cache line; LINE_WORDS = 2**(LINE_OFFSET_W-2).
- MEM_ADDR_W, 12: word-address bits of the internal RAM (2**MEM_ADDR_W words).
- RESP_LATENCY, 2: idle cycles between address acceptance and the first data beat (0 allowed).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_req  in  1  request valid; held by the initiator until mem_addr_ok.
- mem_wr  in  1  1 = write (writeback/store), 0 = read (refill/load).
- mem_burst  in  1  1 = full-line burst, 0 = single word.
- mem_size  in  2  00 byte, 01 half, 1x word; single-word only, ignored in burst.
- mem_addr  in  32  byte address; burst base is forced line-aligned.
- mem_wdata  in  32  write data for the current beat.
- mem_wlast  in  1  initiator marks the final write beat.
- mem_addr_ok  out  1  request accepted this cycle.
- mem_data_ok  out  1  one data beat completes this cycle.
- mem_rdata  out  32  read data, valid when mem_data_ok && !wr.
- resp_err  out  1  sticky protocol error flag.

Behaviour:
- States: IDLE, LAT, XFER.
- Reset values: state IDLE, all counters 0, mem_addr_ok 0, mem_data_ok 0, mem_rdata 0, resp_err 0. RAM contents are not reset.
- IDLE:
  - mem_addr_ok = mem_req (combinational, IDLE only).
  - On acceptance, latch wr, burst, size, addr; beat counter = 0; latency counter = RESP_LATENCY.
  - Next state is LAT, or XFER directly when RESP_LATENCY = 0.
  - mem_addr_ok is 0 in every other state, so a request arriving mid-transaction waits.
- LAT: decrement latency counter; move to XFER when it reaches 1.
- XFER:
  - mem_data_ok = 1 every cycle; one beat per cycle, no back-pressure.
  - Beat word index = line base + beat counter (MEM_ADDR_W bits, higher address bits ignored, wraps modulo RAM size).
  - Read: mem_rdata is registered and presented in the same cycle as mem_data_ok (RAM read issued one cycle ahead).
  - Write: mem_wdata is written on the edge ending the data_ok cycle.
  - Burst ends after LINE_WORDS beats, single after 1 beat; then return to IDLE.
  - Back-to-back transactions: addr_ok may assert in the cycle after the last data_ok.
- Single-word write: byte enables from size and addr[1:0].
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all lanes.
  - Write data is lane-aligned (not shifted by the responder).
- Single-word read always returns the full word; the initiator extracts lanes.
- Error, sticky until reset, sets resp_err on:
  - a write beat where mem_wlast disagrees with "final beat";
  - a misaligned single half (addr[0]=1) or word (addr[1:0]!=0) access.
  - The access still completes normally.
- mem_req dropping during LAT/XFER has no effect; the transaction completes.
- Asynchronous reset mid-transaction aborts immediately. Partial writes already committed remain in RAM.

Optional Feature:
- Macro: DCACHE_MEM_WRAP_BURST_EN.
- Defined: burst reads are critical-word-first. The first beat is word addr[LINE_OFFSET_W-1:2] and the beat index wraps modulo LINE_WORDS. Writes remain base-first.
- Undefined: all bursts start at word 0 of the line; addr word-offset bits are ignored for bursts.

Decomposition:
- Shared package dcache_mem_pkg:
  - resp_state_t enum (IDLE, LAT, XFER);
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - function line_words(offset_w);
  - function byte_en(size, addr_lo) returning 4-bit mask.
- One natural sub-module: dcache_mem_ram, a single-port word RAM with 4-bit byte write enable and registered read, MEM_ADDR_W deep.

Test Plan:
- Refill, RESP_LATENCY=2, RAM[4..7]=A0..A3, read burst at 0x10:
  - addr_ok in cycle 0;
  - data_ok in cycles 3..6 returning A0,A1,A2,A3;
  - IDLE in cycle 7.
- Writeback burst at 0x20, wdata 11,22,33,44, wlast on beat 3 → RAM[8..11] updated, resp_err 0. Repeat with wlast on beat 2 → resp_err=1 and RAM still updated.
- Single byte write size=00, addr=0x43, wdata=0xAB000000 over RAM[16]=0x12345678 → RAM[16]=0xAB345678; read back returns 0xAB345678.
- Back-to-back: mem_req held high across two read bursts → second addr_ok exactly one cycle after the first transaction's last data_ok; no dropped beats.
- resetn low during beat 2 of a write burst → outputs zero asynchronously, beats 0–1 present in RAM, beat 2 absent; next request accepted normally.
- With DCACHE_MEM_WRAP_BURST_EN, read burst at 0x18 over RAM[4..7]=A0..A3 → beats A2,A3,A0,A1. Without the macro → A0..A3.
